// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART init/TX sequencer: bus map, CR layout and FSM states.
package uart_seq_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DFR_W  = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [ADDR_W-1:0] UART_CR    = 5'h00;
   localparam logic [ADDR_W-1:0] UART_TX_RX = 5'h04;
   localparam logic [ADDR_W-1:0] UART_DFR   = 5'h08;
   localparam logic [ADDR_W-1:0] UART_IRQ_M = 5'h0C;

   typedef enum logic [2:0] {
      IDLE,
      W_DFR,
      W_CR,
      W_IRQM,
      POLL,
      W_TX
   } seq_state_e;

   // CR register: low six bits are control, tx_full/rx_empty are read-only status.
   typedef struct packed {
      logic [23:0] rsvd;
      logic        rx_empty;
      logic        tx_full;
      logic [1:0]  rx_fifo_lvl;
      logic [1:0]  tx_fifo_lvl;
      logic        rec_en;
      logic        tr_en;
   } uart_cr_v;

   function automatic logic [DATA_W-1:0] cr_init_word();
      uart_cr_v cr;
      cr             = '0;
      cr.tr_en       = 1'b1;
      cr.rec_en      = 1'b1;
      cr.tx_fifo_lvl = 2'b11;
      cr.rx_fifo_lvl = 2'b11;
      return DATA_W'(cr);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: search starts one past the last grant and wraps; pointer moves on i_upd.
module rr_arb #(
   parameter int unsigned NREQ = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_upd,
   output logic [NREQ-1:0] o_grant_c
);

   localparam int unsigned      IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   always_comb begin
      o_grant_c = '0;
      w_idx     = r_last;
      w_cand    = '0;
      w_found   = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         w_cand = IDX_W'((32'(r_last) + i) % NREQ);
         if (!w_found && i_req[w_cand]) begin
            w_found           = 1'b1;
            w_idx             = w_cand;
            o_grant_c[w_cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last <= LAST_RST;
      end else if (i_upd && w_found) begin
         r_last <= w_idx;
      end
   end

endmodule

// File: rtl/uart_seq.sv
// UART bring-up sequencer: programs DFR/CR/IRQ mask, then polls tx_full and feeds
// bytes from NREQ round-robin requesters into the UART TX register.
module uart_seq
   import uart_seq_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter logic [15:0] DFR_RST = 16'd100
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [DFR_W-1:0]         cfg_dfr,
   input  logic                     cfg_upd,
   input  logic [NREQ-1:0]          tx_req,
   input  logic [BYTE_W*NREQ-1:0]   tx_data,
   output logic [NREQ-1:0]          tx_ack,
   output logic                     init_done,
   output logic [ADDR_W-1:0]        m_addr,
   output logic                     m_re,
   output logic                     m_we,
   output logic [DATA_W-1:0]        m_wd,
   input  logic [DATA_W-1:0]        m_rd
);

   seq_state_e        r_state;
   seq_state_e        w_state_nxt;
   logic [DFR_W-1:0]  r_dfr;
   logic [DFR_W-1:0]  w_dfr_val;
   logic [NREQ-1:0]   w_grant;
   logic [BYTE_W-1:0] w_byte;
   uart_cr_v          w_cr;
   logic              w_tx_full;
   logic              w_upd_grant;
   logic              w_unused_rd;

   // m_rd is only meaningful in POLL, where m_addr holds UART_CR.
   assign w_cr        = uart_cr_v'(m_rd);
   assign w_tx_full   = w_cr.tx_full;
   assign w_unused_rd = ^{w_cr.rsvd, w_cr.rx_empty, w_cr.rx_fifo_lvl,
                          w_cr.tx_fifo_lvl, w_cr.rec_en, w_cr.tr_en};

   // A same-cycle cfg_upd must reach the DFR write that it triggers.
   assign w_dfr_val   = cfg_upd ? cfg_dfr : r_dfr;
   assign w_upd_grant = (r_state == POLL) && (w_state_nxt == W_TX);

   rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (tx_req),
      .i_upd     (w_upd_grant),
      .o_grant_c (w_grant)
   );

   always_comb begin
      w_byte = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_byte = tx_data[BYTE_W*i +: BYTE_W];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   w_state_nxt = W_DFR;
         W_DFR:  w_state_nxt = cfg_upd ? W_DFR : W_CR;
         W_CR:   w_state_nxt = cfg_upd ? W_DFR : W_IRQM;
         W_IRQM: w_state_nxt = cfg_upd ? W_DFR : POLL;
         POLL: begin
            if (cfg_upd) begin
               w_state_nxt = W_DFR;
            end else if (!w_tx_full && (|tx_req)) begin
               w_state_nxt = W_TX;
            end
         end
         W_TX:   w_state_nxt = cfg_upd ? W_DFR : POLL;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each bus access is registered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_dfr     <= DFR_RST;
         tx_ack    <= '0;
         init_done <= 1'b0;
         m_addr    <= '0;
         m_re      <= 1'b0;
         m_we      <= 1'b0;
         m_wd      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_dfr     <= w_dfr_val;
         tx_ack    <= '0;
         init_done <= 1'b0;
         m_addr    <= '0;
         m_re      <= 1'b0;
         m_we      <= 1'b0;
         m_wd      <= '0;
         case (w_state_nxt)
            W_DFR: begin
               m_we   <= 1'b1;
               m_addr <= UART_DFR;
               m_wd   <= DATA_W'(w_dfr_val);
            end
            W_CR: begin
               m_we   <= 1'b1;
               m_addr <= UART_CR;
               m_wd   <= cr_init_word();
            end
            W_IRQM: begin
               m_we   <= 1'b1;
               m_addr <= UART_IRQ_M;
            end
            POLL: begin
               m_re      <= 1'b1;
               m_addr    <= UART_CR;
               init_done <= 1'b1;
            end
            W_TX: begin
               m_we      <= 1'b1;
               m_addr    <= UART_TX_RX;
               m_wd      <= DATA_W'(w_byte);
               tx_ack    <= w_grant;
               init_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_seq.sv
// Directed bench for uart_seq: init sequence, round-robin TX, back-pressure,
// divider reprogramming and reset during a TX write.
module tb_uart_seq;
   import uart_seq_pkg::*;

   localparam int unsigned NREQ = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [15:0]      cfg_dfr = 16'd0;
   logic             cfg_upd = 1'b0;
   logic [NREQ-1:0]  tx_req = '0;
   logic [8*NREQ-1:0] tx_data = '0;
   logic [NREQ-1:0]  tx_ack;
   logic             init_done;
   logic [4:0]       m_addr;
   logic             m_re;
   logic             m_we;
   logic [31:0]      m_wd;
   logic [31:0]      m_rd;
   logic             tx_full = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // UART model: CR reads back the programmed control bits plus the tx_full status (bit 6).
   assign m_rd = (m_addr == UART_CR) ? {24'h0, 1'b0, tx_full, 6'h3F} : 32'h0;

   uart_seq #(
      .NREQ    (NREQ),
      .DFR_RST (16'd100)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cfg_dfr   (cfg_dfr),
      .cfg_upd   (cfg_upd),
      .tx_req    (tx_req),
      .tx_data   (tx_data),
      .tx_ack    (tx_ack),
      .init_done (init_done),
      .m_addr    (m_addr),
      .m_re      (m_re),
      .m_we      (m_we),
      .m_wd      (m_wd),
      .m_rd      (m_rd)
   );

   // {init_done, m_re, m_we, m_addr, m_wd, tx_ack}
   function automatic logic [41:0] mk(input logic id, input logic re, input logic we,
                                      input logic [4:0] a, input logic [31:0] wd,
                                      input logic [1:0] ack);
      return {id, re, we, a, wd, ack};
   endfunction

   function automatic logic [41:0] obs();
      return {init_done, m_re, m_we, m_addr, m_wd, tx_ack};
   endfunction

   always @(negedge clk) begin
      total++;
      if (m_re && m_we) begin
         bad++;
         $display("FAIL re_we_exclusive: got re=%b we=%b want not both", m_re, m_we);
      end
   end

   task automatic test_reset();
      logic [41:0] exp [4];
      exp[0] = mk(1'b0, 1'b0, 1'b1, UART_DFR,   32'd100,       2'b00);
      exp[1] = mk(1'b0, 1'b0, 1'b1, UART_CR,    32'h0000_003F, 2'b00);
      exp[2] = mk(1'b0, 1'b0, 1'b1, UART_IRQ_M, 32'h0,         2'b00);
      exp[3] = mk(1'b1, 1'b1, 1'b0, UART_CR,    32'h0,         2'b00);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (obs() !== 42'h0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", obs());
      end
      rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (obs() !== exp[c]) begin
            bad++;
            $display("FAIL init_cycle%0d: got %h want %h", c + 1, obs(), exp[c]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [41:0] poll_v;
      logic [41:0] e;
      poll_v  = mk(1'b1, 1'b1, 1'b0, UART_CR, 32'h0, 2'b00);
      tx_data = {8'h42, 8'h41};
      tx_req  = 2'b11;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         e = (b % 2 == 0) ? mk(1'b1, 1'b0, 1'b1, UART_TX_RX, 32'h41, 2'b01)
                          : mk(1'b1, 1'b0, 1'b1, UART_TX_RX, 32'h42, 2'b10);
         total++;
         if (obs() !== e) begin
            bad++;
            $display("FAIL rr_tx%0d: got %h want %h", b, obs(), e);
         end
         if (b == 3) tx_req = 2'b00;
         @(negedge clk);
         total++;
         if (obs() !== poll_v) begin
            bad++;
            $display("FAIL rr_poll%0d: got %h want %h", b, obs(), poll_v);
         end
      end
   endtask

   task automatic test_tx_full();
      logic [41:0] poll_v;
      logic [41:0] e;
      logic        found;
      poll_v  = mk(1'b1, 1'b1, 1'b0, UART_CR, 32'h0, 2'b00);
      e       = mk(1'b1, 1'b0, 1'b1, UART_TX_RX, 32'h42, 2'b10);
      tx_full = 1'b1;
      tx_req  = 2'b10;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (obs() !== poll_v) begin
            bad++;
            $display("FAIL full_hold%0d: got %h want %h", c, obs(), poll_v);
         end
      end
      tx_full = 1'b0;
      found   = 1'b0;
      for (int c = 0; c < 2 && !found; c++) begin
         @(negedge clk);
         if (tx_ack !== 2'b00) found = 1'b1;
      end
      total++;
      if (!found || obs() !== e) begin
         bad++;
         $display("FAIL full_release_ack: got %h want %h within 2 cycles", obs(), e);
      end
      tx_req = 2'b00;
      @(negedge clk);
      total++;
      if (obs() !== poll_v) begin
         bad++;
         $display("FAIL full_after: got %h want %h", obs(), poll_v);
      end
   endtask

   task automatic test_cfg_upd();
      logic [41:0] exp [5];
      int          low;
      exp[0] = mk(1'b1, 1'b0, 1'b1, UART_TX_RX, 32'h55,        2'b01);
      exp[1] = mk(1'b0, 1'b0, 1'b1, UART_DFR,   32'd434,       2'b00);
      exp[2] = mk(1'b0, 1'b0, 1'b1, UART_CR,    32'h0000_003F, 2'b00);
      exp[3] = mk(1'b0, 1'b0, 1'b1, UART_IRQ_M, 32'h0,         2'b00);
      exp[4] = mk(1'b1, 1'b1, 1'b0, UART_CR,    32'h0,         2'b00);
      tx_data = {8'h42, 8'h55};
      tx_req  = 2'b01;
      low     = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         cfg_upd = 1'b0;
         total++;
         if (obs() !== exp[c]) begin
            bad++;
            $display("FAIL cfg_upd_cycle%0d: got %h want %h", c, obs(), exp[c]);
         end
         if (!init_done) low++;
         if (c == 0) begin
            tx_req  = 2'b00;
            cfg_dfr = 16'd434;
            cfg_upd = 1'b1;
         end
      end
      total++;
      if (low !== 3) begin
         bad++;
         $display("FAIL cfg_upd_init_low: got %0d cycles want 3", low);
      end
   endtask

   task automatic test_cfg_restart();
      logic [41:0] exp [6];
      exp[0] = mk(1'b0, 1'b0, 1'b1, UART_DFR,   32'd200,       2'b00);
      exp[1] = mk(1'b0, 1'b0, 1'b1, UART_CR,    32'h0000_003F, 2'b00);
      exp[2] = mk(1'b0, 1'b0, 1'b1, UART_DFR,   32'd300,       2'b00);
      exp[3] = mk(1'b0, 1'b0, 1'b1, UART_CR,    32'h0000_003F, 2'b00);
      exp[4] = mk(1'b0, 1'b0, 1'b1, UART_IRQ_M, 32'h0,         2'b00);
      exp[5] = mk(1'b1, 1'b1, 1'b0, UART_CR,    32'h0,         2'b00);
      cfg_dfr = 16'd200;
      cfg_upd = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cfg_upd = 1'b0;
         total++;
         if (obs() !== exp[c]) begin
            bad++;
            $display("FAIL cfg_restart_cycle%0d: got %h want %h", c, obs(), exp[c]);
         end
         if (c == 1) begin
            cfg_dfr = 16'd300;
            cfg_upd = 1'b1;
         end
      end
   endtask

   task automatic test_reset_mid_tx();
      logic [41:0] exp [6];
      exp[0] = mk(1'b0, 1'b0, 1'b1, UART_DFR,   32'd100,       2'b00);
      exp[1] = mk(1'b0, 1'b0, 1'b1, UART_CR,    32'h0000_003F, 2'b00);
      exp[2] = mk(1'b0, 1'b0, 1'b1, UART_IRQ_M, 32'h0,         2'b00);
      exp[3] = mk(1'b1, 1'b1, 1'b0, UART_CR,    32'h0,         2'b00);
      exp[4] = mk(1'b1, 1'b0, 1'b1, UART_TX_RX, 32'h42,        2'b10);
      exp[5] = mk(1'b1, 1'b1, 1'b0, UART_CR,    32'h0,         2'b00);
      tx_data = {8'h42, 8'h00};
      tx_req  = 2'b10;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if (obs() !== 42'h0) begin
         bad++;
         $display("FAIL rst_mid_tx_immediate: got %h want 0", obs());
      end
      @(posedge clk);
      #1;
      total++;
      if (obs() !== 42'h0) begin
         bad++;
         $display("FAIL rst_mid_tx_no_ack: got %h want 0", obs());
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (obs() !== exp[c]) begin
            bad++;
            $display("FAIL rst_rerun_cycle%0d: got %h want %h", c, obs(), exp[c]);
         end
         if (c == 4) tx_req = 2'b00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_tx_full();
      test_cfg_upd();
      test_cfg_restart();
      test_reset_mid_tx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_seq.md
UART_SEQ -- requirements
Module: uart_seq

Interface
REQ-001 Parameter NREQ, default 2: number of TX requesters (2..4).
REQ-002 Parameter DFR_RST, default 16'd100: divider value programmed after reset.
REQ-003 clk  in  1  clock, single clock domain.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 cfg_dfr  in  16  new divider value, sampled on cfg_upd.
REQ-006 cfg_upd  in  1  one-cycle pulse requesting reprogramming of the divider.
REQ-007 tx_req  in  NREQ  per-requester byte valid, held until acked.
REQ-008 tx_data  in  8*NREQ  per-requester byte, stable while tx_req is high.
REQ-009 tx_ack  out  NREQ  one-hot, one-cycle pulse: byte accepted.
REQ-010 init_done  out  1  high while the UART is configured and serving requests.
REQ-011 m_addr  out  5  address on the UART simple bus.
REQ-012 m_re  out  1  read enable on the UART simple bus.
REQ-013 m_we  out  1  write enable on the UART simple bus.
REQ-014 m_wd  out  32  write data on the UART simple bus.
REQ-015 m_rd  in  32  read data from the UART simple bus, combinational from m_addr.

Function
REQ-016 States: IDLE, W_DFR, W_CR, W_IRQM, POLL, W_TX.
- IDLE -> W_DFR one cycle after reset release.
- W_DFR -> W_CR -> W_IRQM -> POLL, one cycle each.
REQ-017 Each state's bus access occupies exactly one cycle:
- W_DFR: m_we=1, m_addr=UART_DFR, m_wd={16'0, dfr_reg}.
- W_CR: m_we=1, m_addr=UART_CR, m_wd = tr_en=1, rec_en=1, tx_fifo_lvl=2'b11, rx_fifo_lvl=2'b11, other bits 0.
- W_IRQM: m_we=1, m_addr=UART_IRQ_M, m_wd=0 (all interrupts masked).
REQ-018 POLL: m_re=1, m_addr=UART_CR; tx_full is sampled from m_rd in the same cycle.
REQ-019 POLL transitions:
- tx_full=0 and any tx_req high: go to W_TX with the round-robin winner latched.
- Otherwise: remain in POLL.
REQ-020 W_TX: m_we=1, m_addr=UART_TX_RX, m_wd={24'0, winner tx_data}, tx_ack[winner]=1; then return to POLL.
REQ-021 Round-robin arbitration: the search starts at index last_grant+1 and wraps modulo NREQ; last_grant resets to NREQ-1, so requester 0 has first priority.
REQ-022 Latency: minimum 2 cycles per byte (POLL then W_TX); a single active requester sees tx_ack at most 2 cycles after tx_req, provided tx_full=0.
REQ-023 While tx_full=1, no tx_ack is issued and POLL repeats every cycle.
REQ-024 cfg_upd latches cfg_dfr into dfr_reg; dfr_reg resets to DFR_RST.
- cfg_upd in POLL: next state is W_DFR.
- cfg_upd in W_TX: W_TX completes first, then W_DFR.
- cfg_upd in W_DFR..W_IRQM: the value is latched and the sequence restarts at W_DFR.
REQ-025 init_done=1 only in POLL and W_TX; it drops during any reprogramming.
REQ-026 m_re and m_we are never both high; all m_* outputs are 0 in IDLE.
REQ-027 A requester dropping tx_req before ack is legal; it is excluded at the next POLL.

Reset
REQ-028 On rstn low, all state resets asynchronously: state=IDLE, dfr_reg=DFR_RST, last_grant=NREQ-1, all outputs 0.
REQ-029 Reset asserted mid-W_TX aborts the write with no ack; after reset release the full init sequence reruns.

Structure
REQ-030 The state enum and the address constants UART_CR, UART_TX_RX, UART_DFR and UART_IRQ_M live in the shared uart package, along with the uart_cr_v bit layout.
REQ-031 Arbitration is a sub-module rr_arb (NREQ req in, one-hot grant out, update strobe).
- FSM, registers and bus muxing stay in uart_seq.

Verification
REQ-032 Reset release, uart model attached -> bus writes DFR=100, then CR, then IRQ_M=0 on consecutive cycles; init_done high on cycle 4.
REQ-033 tx_req=2'b11, data 0x41/0x42, tx_full=0 -> acks alternate 0,1,0,1; the UART receives 0x41,0x42,0x41,0x42, one byte every 2 cycles.
REQ-034 tx_full forced 1 for 10 cycles with tx_req[1]=1 -> no ack and no TX write; ack arrives 2 cycles after tx_full clears.
REQ-035 cfg_upd with cfg_dfr=16'd434 during W_TX -> TX write completes with ack, then a DFR write of 434, CR, IRQ_M; init_done low for 3 cycles.
REQ-036 rstn pulsed low during W_TX -> no ack, outputs 0 immediately; the init sequence repeats with DFR_RST.
